// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and bridge FSM state type.
// Used by the master bridge and AHB-Lite slaves.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_lite_align_check.sv
// Combinational legality check of a request's size/address pair.
// Ports: i_size (HSIZE code), i_addr_lo (addr[1:0]), o_legal.
module ahb_lite_align_check
    import ahb_lite_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic       o_legal
);

    always_comb begin
        o_legal = 1'b0;
        unique case (i_size)
            HSIZE_BYTE: o_legal = 1'b1;
            HSIZE_HALF: o_legal = ~i_addr_lo[0];
            HSIZE_WORD: o_legal = (i_addr_lo == 2'b00);
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// Single-outstanding AHB-Lite master: valid/ready request in,
// SINGLE transfer on the bus, one-cycle response strobe out.
// Ports: HCLK/HRESET; req_* request channel; rsp_* response;
// HADDR..HWRITE AHB master outputs; HRDATA/HREADY/HRESP inputs.
module ahb_lite_master_bridge
    import ahb_lite_pkg::*;
#(
    parameter int HADDR_BITS     = 25,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_BITS       = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [HADDR_BITS-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [HADDR_BITS-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic                  HSEL,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [31:0]           HWDATA,
    output logic                  HWRITE,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [CNT_BITS-1:0] TO_LIM = CNT_BITS'(TIMEOUT_CYCLES);

    state_t              r_state;
    logic [31:0]         r_wdata;
    logic [CNT_BITS-1:0] r_cnt;

    logic                w_legal;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic                w_to_hit;

    ahb_lite_align_check u_align (
        .i_size    (req_size),
        .i_addr_lo (req_addr[1:0]),
        .o_legal   (w_legal)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign HBURST    = HBURST_SINGLE;
    assign w_cnt_nxt = r_cnt + 1'b1;
    // Only consulted on HREADY-low cycles, so completion wins a tie.
    assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == TO_LIM);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_wdata     <= '0;
            r_cnt       <= '0;
            HTRANS      <= HTRANS_IDLE;
            HSEL        <= 1'b0;
            HADDR       <= '0;
            HSIZE       <= '0;
            HWRITE      <= 1'b0;
            HWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wdata <= req_wdata;
                        if (w_legal) begin
                            r_state <= ST_ADDR;
                            r_cnt   <= '0;
                            HTRANS  <= HTRANS_NONSEQ;
                            HSEL    <= 1'b1;
                            HADDR   <= req_addr;
                            HSIZE   <= req_size;
                            HWRITE  <= req_write;
                        end else begin
                            r_state     <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                        HTRANS  <= HTRANS_IDLE;
                        HSEL    <= 1'b0;
                        HWDATA  <= r_wdata;
                    end else if (w_to_hit) begin
                        r_state     <= ST_RESP;
                        HTRANS      <= HTRANS_IDLE;
                        HSEL        <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        // HRESP with HREADY here is a malformed error; fail it.
                        r_state     <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= HRESP;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (HWRITE || HRESP) ? '0 : HRDATA;
                    end else if (HRESP) begin
                        r_state <= ST_ERR;
                        r_cnt   <= w_cnt_nxt;
                    end else if (w_to_hit) begin
                        r_state     <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_ERR: begin
                    if (HREADY) begin
                        r_state     <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                    end else if (w_to_hit) begin
                        r_state     <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for ahb_lite_master_bridge with a scripted slave.
// Ports: none (top-level bench).
module tb_ahb_lite_master_bridge;

    localparam int AW = 25;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] HADDR;
    logic [2:0]    HBURST;
    logic          HSEL;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic [31:0]   HWDATA;
    logic          HWRITE;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic          HRESP;

    int checks = 0;
    int errors = 0;

    ahb_lite_master_bridge #(
        .HADDR_BITS     (AW),
        .TIMEOUT_CYCLES (4),
        .CNT_BITS       (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .HADDR       (HADDR),
        .HBURST      (HBURST),
        .HSEL        (HSEL),
        .HSIZE       (HSIZE),
        .HTRANS      (HTRANS),
        .HWDATA      (HWDATA),
        .HWRITE      (HWRITE),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [31:0]   wdata;
        int            waits;
        logic          serr;
        logic [31:0]   hrdata;
        logic [31:0]   e_rdata;
        logic          e_err;
        logic          e_to;
        int            e_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic run_vec(input vec_t v);
        int  lat;
        int  nonseq;
        int  d;
        bit  done;
        bit  legal;
        legal = (v.e_lat != 1);
        @(negedge HCLK);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_size  = v.size;
        req_wdata = v.wdata;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = v.hrdata;
        lat    = 0;
        nonseq = 0;
        done   = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge HCLK);
            req_valid = 1'b0;
            req_addr  = '1;
            req_wdata = '0;
            req_write = ~v.wr;
            if (HTRANS == 2'b10) nonseq++;
            if (rsp_valid) begin
                lat  = k;
                done = 1'b1;
            end else begin
                if (k == 1 && legal) begin
                    chk("haddr", 32'(HADDR), 32'(v.addr));
                    chk("hwrite", 32'(HWRITE), 32'(v.wr));
                    chk("hsize", 32'(HSIZE), 32'(v.size));
                end
                if (k == 2 && legal && v.wr)
                    chk("hwdata", HWDATA, v.wdata);
                d = k - 2;
                if (k == 1) begin
                    HREADY = 1'b1; HRESP = 1'b0;
                end else if (d < v.waits) begin
                    HREADY = 1'b0; HRESP = 1'b0;
                end else if (v.serr) begin
                    HRESP  = 1'b1;
                    HREADY = (d != v.waits);
                end else begin
                    HREADY = 1'b1; HRESP = 1'b0;
                end
            end
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        chk("latency", 32'(lat), 32'(v.e_lat));
        chk("nonseq_cycles", 32'(nonseq), legal ? 32'd1 : 32'd0);
        if (done) begin
            chk("rsp_err", 32'(rsp_err), 32'(v.e_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(v.e_to));
            chk("rsp_rdata", rsp_rdata, v.e_rdata);
            @(negedge HCLK);
            chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
            chk("rdata_held", rsp_rdata, v.e_rdata);
        end
    endtask

    initial begin
        int bad;
        // wr addr size wdata waits serr hrdata | rdata err to lat
        vecs[0]  = '{1'b1, 25'h100, 3'd2, 32'hDEADBEEF, 0, 1'b0,
                     32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 3};
        vecs[1]  = '{1'b0, 25'h040, 3'd2, 32'h0, 0, 1'b0,
                     32'h12345678, 32'h12345678, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, 25'h041, 3'd0, 32'h0, 2, 1'b0,
                     32'h000000AB, 32'h000000AB, 1'b0, 1'b0, 5};
        vecs[3]  = '{1'b1, 25'h042, 3'd1, 32'h0000BEEF, 1, 1'b0,
                     32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 4};
        vecs[4]  = '{1'b0, 25'h080, 3'd2, 32'h0, 0, 1'b1,
                     32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 4};
        vecs[5]  = '{1'b1, 25'h084, 3'd2, 32'h11111111, 1, 1'b1,
                     32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 5};
        vecs[6]  = '{1'b0, 25'h088, 3'd2, 32'h0, 3, 1'b0,
                     32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 1'b0, 6};
        vecs[7]  = '{1'b0, 25'h08C, 3'd2, 32'h0, 4, 1'b0,
                     32'h77777777, 32'h0, 1'b0, 1'b1, 6};
        vecs[8]  = '{1'b0, 25'h002, 3'd2, 32'h0, 0, 1'b0,
                     32'h99999999, 32'h0, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b1, 25'h001, 3'd1, 32'h1, 0, 1'b0,
                     32'h99999999, 32'h0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 25'h000, 3'd3, 32'h0, 0, 1'b0,
                     32'h99999999, 32'h0, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b0, 25'h001, 3'd2, 32'h0, 0, 1'b0,
                     32'h99999999, 32'h0, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b1, 25'h1FFFFFC, 3'd2, 32'h0BADCAFE, 0, 1'b0,
                     32'h33333333, 32'h0, 1'b0, 1'b0, 3};

        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hsel", 32'(HSEL), 32'd0);
        chk("rst_haddr", 32'(HADDR), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("hburst", 32'(HBURST), 32'd0);
        HRESET = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Address phase stretched by HREADY low; HRESP there is ignored.
        @(negedge HCLK);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = 25'h200; req_size = 3'd2;
        req_wdata = 32'h11223344;
        @(negedge HCLK);
        req_valid = 1'b0;
        chk("aw_nonseq1", 32'(HTRANS), 32'd2);
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK);
        chk("aw_nonseq2", 32'(HTRANS), 32'd2);
        chk("aw_hsel", 32'(HSEL), 32'd1);
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        chk("aw_htrans_data", 32'(HTRANS), 32'd0);
        chk("aw_hwdata", HWDATA, 32'h11223344);
        @(negedge HCLK);
        chk("aw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("aw_rsp_err", 32'(rsp_err), 32'd0);

        // Reset while the slave stalls the data phase.
        @(negedge HCLK);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = 25'h300; req_size = 3'd2;
        req_wdata = 32'hFEEDFACE;
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b0;
        chk("mr_hwdata_pre", HWDATA, 32'hFEEDFACE);
        @(negedge HCLK);
        #1 HRESET = 1'b1;
        #1;
        chk("mr_haddr", 32'(HADDR), 32'd0);
        chk("mr_hwdata", HWDATA, 32'd0);
        chk("mr_hwrite", 32'(HWRITE), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd1);
        @(negedge HCLK);
        HRESET = 1'b0;
        HREADY = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge HCLK);
            if (rsp_valid || !req_ready) bad++;
        end
        chk("mr_no_response", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
